// File: rtl/router_out_port_e_pkg.sv
// Shared NoC definitions for the East output port.
// Holds the default packet geometry, header field positions, the source
// direction enum used as the arbitration index, and a header sanity helper.
package noc_pkg;

  localparam int WIDTH = 35;
  localparam int DEPTH = 4;

  localparam int SRC_X_HI = 34;
  localparam int SRC_X_LO = 33;
  localparam int SRC_Y_HI = 32;
  localparam int SRC_Y_LO = 31;
  localparam int DST_X_HI = 30;
  localparam int DST_X_LO = 29;
  localparam int DST_Y_HI = 28;
  localparam int DST_Y_LO = 27;

  typedef enum logic [1:0] {
    DIR_N  = 2'd0,
    DIR_W  = 2'd1,
    DIR_S  = 2'd2,
    DIR_PE = 2'd3
  } dir_e;

  typedef logic [WIDTH-1:0] packet_t;

  // A packet travelling East must never target a column behind its source.
  function automatic logic route_bad(input logic [1:0] src_x, input logic [1:0] dst_x);
    return dst_x < src_x;
  endfunction

endpackage

// File: rtl/router_out_port_e_if.sv
// Bundle of all handshake/bus signals of the East output port.
//   master : the environment (input routers + downstream link)
//   slave  : the output port itself
// Signals: {n,w,s,pe}_valid/_data/_ready sink channels, e_valid/e_data/e_ready
// source channel, route_err sticky flag, occupancy FIFO count.
interface router_out_port_e_if #(
  parameter int WIDTH = noc_pkg::WIDTH,
  parameter int DEPTH = noc_pkg::DEPTH
);
  logic             n_valid,  w_valid,  s_valid,  pe_valid;
  logic [WIDTH-1:0] n_data,   w_data,   s_data,   pe_data;
  logic             n_ready,  w_ready,  s_ready,  pe_ready;
  logic             e_valid;
  logic [WIDTH-1:0] e_data;
  logic             e_ready;
  logic             route_err;
  logic [$clog2(DEPTH):0] occupancy;

  modport master (
    output n_valid, n_data, w_valid, w_data, s_valid, s_data, pe_valid, pe_data, e_ready,
    input  n_ready, w_ready, s_ready, pe_ready, e_valid, e_data, route_err, occupancy
  );

  modport slave (
    input  n_valid, n_data, w_valid, w_data, s_valid, s_data, pe_valid, pe_data, e_ready,
    output n_ready, w_ready, s_ready, pe_ready, e_valid, e_data, route_err, occupancy
  );
endinterface

// File: rtl/router_out_port_e_rr_arb4.sv
// Four-way round-robin arbiter.
//   clk, rst_n : clock, async active-low reset (pointer returns to N)
//   req_i      : request per source, indexed by dir_e
//   advance_i  : the granted request was accepted this cycle
//   grant_o    : one-hot grant, first request at or after the pointer
module rr_arb4
  import noc_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req_i,
  input  logic       advance_i,
  output logic [3:0] grant_o
);

  logic [1:0] ptr_q, ptr_d;
  logic [1:0] gidx;
  logic       found;

  function automatic logic [1:0] rot(input logic [1:0] base, input int off);
    return base + 2'(off);
  endfunction

  always_comb begin
    grant_o = '0;
    gidx    = ptr_q;
    found   = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && req_i[rot(ptr_q, i)]) begin
        grant_o[rot(ptr_q, i)] = 1'b1;
        gidx                   = rot(ptr_q, i);
        found                  = 1'b1;
      end
    end
    // Winner moves to lowest priority only when its packet was actually taken.
    ptr_d = advance_i ? gidx + 2'd1 : ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ptr_q <= 2'(DIR_N);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/router_out_port_e.sv
// East output port of a mesh router: round-robin merge of N/W/S/PE packets
// into a DEPTH-entry FIFO feeding the East link.
//   clk, rst_n : clock, async active-low reset (FIFO emptied, flags cleared)
//   bus        : slave side of router_out_port_e_if (all channels + status)
module router_out_port_e #(
  parameter int WIDTH = noc_pkg::WIDTH,
  parameter int DEPTH = noc_pkg::DEPTH
) (
  input  logic                clk,
  input  logic                rst_n,
  router_out_port_e_if.slave  bus
);
  import noc_pkg::*;

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  logic [3:0]       req, grant, rdy;
  logic [WIDTH-1:0] src_data [4];
  logic [WIDTH-1:0] push_data;
  logic             full, push, pop;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [OW-1:0]    occ_q, occ_d;
  logic             err_q;

  assign req[DIR_N]       = bus.n_valid;
  assign req[DIR_W]       = bus.w_valid;
  assign req[DIR_S]       = bus.s_valid;
  assign req[DIR_PE]      = bus.pe_valid;
  assign src_data[DIR_N]  = bus.n_data;
  assign src_data[DIR_W]  = bus.w_data;
  assign src_data[DIR_S]  = bus.s_data;
  assign src_data[DIR_PE] = bus.pe_data;

  rr_arb4 u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_i     (req),
    .advance_i (push),
    .grant_o   (grant)
  );

  // Full blocks input regardless of a same-cycle pop, so ready never
  // depends on e_ready. Gating with rst_n keeps ready low during reset.
  assign full = (occ_q == OW'(DEPTH));
  assign rdy  = grant & {4{rst_n & ~full}};
  assign push = |rdy;
  assign pop  = (occ_q != '0) & bus.e_ready;

  always_comb begin
    push_data = '0;
    for (int i = 0; i < 4; i++) begin
      if (grant[i]) push_data = src_data[i];
    end
  end

  always_comb begin
    occ_d = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OW'(1);
      2'b01:   occ_d = occ_q - OW'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Storage is cleared on reset so e_data reads zero out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= push_data;
        wr_q        <= wr_q + AW'(1);
        if (route_bad(push_data[WIDTH-1 -: 2], push_data[WIDTH-5 -: 2])) err_q <= 1'b1;
      end
      if (pop) rd_q <= rd_q + AW'(1);
      occ_q <= occ_d;
    end
  end

  assign bus.n_ready   = rdy[DIR_N];
  assign bus.w_ready   = rdy[DIR_W];
  assign bus.s_ready   = rdy[DIR_S];
  assign bus.pe_ready  = rdy[DIR_PE];
  assign bus.e_valid   = (occ_q != '0);
  assign bus.e_data    = mem_q[rd_q];
  assign bus.route_err = err_q;
  assign bus.occupancy = occ_q;

endmodule

// File: tb/tb_router_out_port_e.sv
module tb_router_out_port_e;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  router_out_port_e_if bus ();

  router_out_port_e dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  packet_t srcq [4][$];
  packet_t exp_q [$];
  int      acc_log [$];
  int      m_ptr = 0;
  logic    m_err = 1'b0;
  logic [3:0] drv_acc;
  int      pl_cnt = 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] dut_vld();
    return {bus.pe_valid, bus.s_valid, bus.w_valid, bus.n_valid};
  endfunction

  function automatic logic [3:0] dut_rdy();
    return {bus.pe_ready, bus.s_ready, bus.w_ready, bus.n_ready};
  endfunction

  function automatic packet_t src_data(input int i);
    case (i)
      0:       return bus.n_data;
      1:       return bus.w_data;
      2:       return bus.s_data;
      default: return bus.pe_data;
    endcase
  endfunction

  task automatic drive(input int i, input logic v, input packet_t d);
    case (i)
      0:       begin bus.n_valid  = v; bus.n_data  = d; end
      1:       begin bus.w_valid  = v; bus.w_data  = d; end
      2:       begin bus.s_valid  = v; bus.s_data  = d; end
      default: begin bus.pe_valid = v; bus.pe_data = d; end
    endcase
  endtask

  function automatic packet_t mk(input int sx, input int sy, input int dx, input int dy);
    packet_t p;
    p = {2'(sx), 2'(sy), 2'(dx), 2'(dy), 27'(pl_cnt)};
    pl_cnt++;
    return p;
  endfunction

  // Senders: hold valid/data until the DUT shows ready at a clock edge.
  always begin
    @(negedge clk);
    drv_acc = dut_rdy() & dut_vld();
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (drv_acc[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      if (srcq[i].size() > 0) drive(i, 1'b1, srcq[i][0]);
      else                    drive(i, 1'b0, '0);
    end
  end

  // Reference model: the expected FIFO is a queue, grant is a scan from the
  // pointer, and every output is compared on each cycle out of reset.
  always begin : model
    int      g;
    int      s;
    logic    pop_m;
    logic [3:0] v, dr, er;
    packet_t in_d;
    @(negedge clk);
    g = -1;
    pop_m = 1'b0;
    in_d = '0;
    if (!rst_n) begin
      exp_q.delete();
      m_ptr = 0;
      m_err = 1'b0;
    end else begin
      v  = dut_vld();
      dr = dut_rdy();
      for (int k = 0; k < 4; k++) begin
        s = (m_ptr + k) % 4;
        if (g < 0 && v[s]) g = s;
      end
      if (exp_q.size() == DEPTH) g = -1;
      er = (g >= 0) ? (4'b0001 << g) : 4'b0000;
      chk("ready", 64'(dr), 64'(er));
      chk("e_valid", 64'(bus.e_valid), 64'(exp_q.size() != 0));
      if (exp_q.size() != 0) chk("e_data", 64'(bus.e_data), 64'(exp_q[0]));
      chk("occupancy", 64'(bus.occupancy), 64'(exp_q.size()));
      chk("route_err", 64'(bus.route_err), 64'(m_err));
      for (int k = 0; k < 4; k++) if (dr[k] && v[k]) acc_log.push_back(k);
      pop_m = (exp_q.size() != 0) && bus.e_ready;
      if (g >= 0) in_d = src_data(g);
    end
    @(posedge clk);
    if (rst_n) begin
      if (pop_m) void'(exp_q.pop_front());
      if (g >= 0) begin
        if (in_d[30:29] < in_d[34:33]) m_err = 1'b1;
        exp_q.push_back(in_d);
        m_ptr = (g + 1) % 4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic busy();
    logic b;
    b = exp_q.size() != 0;
    for (int i = 0; i < 4; i++) if (srcq[i].size() != 0) b = 1'b1;
    return b;
  endfunction

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy() && n < 200) begin tick(); n++; end
    tick();
    if (n >= 200) chk({nm, "_timeout"}, 64'(1), 64'(0));
  endtask

  task automatic wait_occ(input int want, input string nm);
    int n;
    n = 0;
    while (exp_q.size() != want && n < 100) begin tick(); n++; end
    if (n >= 100) chk({nm, "_timeout"}, 64'(exp_q.size()), 64'(want));
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1);
  end

  initial begin : stim
    int n;
    int exp_order [8] = '{0, 1, 2, 3, 0, 1, 2, 3};
    for (int i = 0; i < 4; i++) drive(i, 1'b0, '0);
    bus.e_ready = 1'b0;

    // Reset values
    #3;
    chk("rst_e_valid", 64'(bus.e_valid), 64'(0));
    chk("rst_e_data", 64'(bus.e_data), 64'(0));
    chk("rst_occ", 64'(bus.occupancy), 64'(0));
    chk("rst_ready", 64'(dut_rdy()), 64'(0));
    chk("rst_err", 64'(bus.route_err), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // 1: single PE packet
    bus.e_ready = 1'b1;
    srcq[3].push_back(35'h0_8000_0012);
    n = 0;
    while (!bus.e_valid && n < 20) begin tick(); n++; end
    chk("t1_e_valid", 64'(bus.e_valid), 64'(1));
    chk("t1_e_data", 64'(bus.e_data), 64'h0_8000_0012);
    chk("t1_occ1", 64'(bus.occupancy), 64'(1));
    tick();
    chk("t1_occ0", 64'(bus.occupancy), 64'(0));
    chk("t1_err", 64'(bus.route_err), 64'(0));
    wait_idle("t1");

    // 2: fairness with all four sources streaming
    acc_log.delete();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < 4; i++) srcq[i].push_back(mk(i % 2, r, 3, i));
    wait_idle("t2");
    chk("t2_count", 64'(acc_log.size()), 64'(12));
    for (int k = 0; k < 8; k++)
      if (k < acc_log.size()) chk("t2_order", 64'(acc_log[k]), 64'(exp_order[k]));

    // 3: backpressure, 6 packets into 4 entries
    bus.e_ready = 1'b0;
    for (int k = 0; k < 6; k++) srcq[0].push_back(mk(1, 1, 2, k % 4));
    repeat (10) tick();
    chk("t3_occ_full", 64'(bus.occupancy), 64'(4));
    chk("t3_n_ready", 64'(bus.n_ready), 64'(0));
    chk("t3_n_valid", 64'(bus.n_valid), 64'(1));
    chk("t3_e_valid", 64'(bus.e_valid), 64'(1));
    bus.e_ready = 1'b1;
    wait_idle("t3");
    chk("t3_occ_end", 64'(bus.occupancy), 64'(0));

    // 4: steady push+pop at occupancy 2 across pointer wrap
    bus.e_ready = 1'b0;
    for (int k = 0; k < 2; k++) srcq[0].push_back(mk(0, 2, 1, k));
    wait_occ(2, "t4_fill");
    for (int k = 0; k < 10; k++) srcq[0].push_back(mk(2, 3, 3, k % 4));
    tick();
    bus.e_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("t4_occ_hold", 64'(bus.occupancy), 64'(2));
    end
    wait_idle("t4");

    // 5: header error from W, still forwarded, sticky
    srcq[1].push_back(mk(3, 0, 1, 0));
    wait_idle("t5");
    chk("t5_err", 64'(bus.route_err), 64'(1));
    srcq[0].push_back(mk(0, 0, 3, 0));
    wait_idle("t5b");
    chk("t5_err_sticky", 64'(bus.route_err), 64'(1));

    // 6: reset mid-stream with occupancy 3
    bus.e_ready = 1'b0;
    for (int k = 0; k < 4; k++) srcq[0].push_back(mk(1, 0, 2, k));
    wait_occ(3, "t6_fill");
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) srcq[i].delete();
    #1;
    chk("t6_e_valid", 64'(bus.e_valid), 64'(0));
    chk("t6_e_data", 64'(bus.e_data), 64'(0));
    chk("t6_occ", 64'(bus.occupancy), 64'(0));
    chk("t6_ready", 64'(dut_rdy()), 64'(0));
    chk("t6_err", 64'(bus.route_err), 64'(0));
    tick(); tick();
    rst_n = 1'b1;
    tick();
    bus.e_ready = 1'b1;
    acc_log.delete();
    for (int i = 0; i < 4; i++) srcq[i].push_back(mk(0, i, 2, 1));
    wait_idle("t6");
    chk("t6_count", 64'(acc_log.size()), 64'(4));
    if (acc_log.size() > 0) chk("t6_first_n", 64'(acc_log[0]), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
